// File: rtl/fir_coeff_loader_if.sv
// BRAM port B read bundle between fir_coeff_loader (master) and the
// MicroBlaze-written coefficient BRAM (slave).
interface fir_coeff_loader_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] filter_coeff_addr;
  logic              filter_coeff_en;
  logic [31:0]       filter_coeff_data;

  modport master (
    output filter_coeff_addr,
    output filter_coeff_en,
    input  filter_coeff_data
  );

  modport slave (
    input  filter_coeff_addr,
    input  filter_coeff_en,
    output filter_coeff_data
  );
endinterface

// File: rtl/fir_coeff_loader.sv
// Double-buffered coefficient loader for fir_filter: commits the shadow set on
// each vsync rising edge, then refills the shadow bank from BRAM port B.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for vsync edge; commits shadow if a valid set is held
// S_FETCH | issuing BRAM reads, address 0..NUM_COEFF, one per clock
// S_DRAIN | capturing the final read word before returning to idle
module fir_coeff_loader #(
  parameter int NUM_COEFF = 25,
  parameter int COEFF_W   = 16,
  parameter int ADDR_W    = 6,
  parameter int RST_SHIFT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vs_i,
  fir_coeff_loader_if.master             bram,
  output logic [NUM_COEFF*COEFF_W-1:0]   coeff_o,
  output logic [4:0]                     shift_o,
  output logic                           update_o,
  output logic                           busy_o,
  output logic                           abort_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int                  CENTRE    = NUM_COEFF / 2;
  localparam logic [COEFF_W-1:0]  ID_TAP    = COEFF_W'(2 ** RST_SHIFT);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(NUM_COEFF);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_vs_q;
  logic                w_edge;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                r_en;
  logic                w_en_nxt;
  logic                w_commit;
  logic                w_restart;
  logic                w_done;

  logic                r_cap_vld;
  logic [ADDR_W-1:0]   r_cap_idx;
  logic [COEFF_W-1:0]  r_shadow [NUM_COEFF];
  logic                r_shadow_vbit;
  logic [4:0]          r_shadow_shift;
  logic                r_shadow_valid;

  logic [NUM_COEFF*COEFF_W-1:0] r_coeff;
  logic [4:0]          r_shift;
  logic                r_update;
  logic                r_abort;
  logic                w_unused;

  assign w_edge = vs_i & ~r_vs_q;

  // vs_q resets high so a vsync already high out of reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_vs_q  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_en    <= w_en_nxt;
      r_vs_q  <= vs_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_en_nxt    = 1'b0;
    w_commit    = 1'b0;
    w_restart   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
          w_en_nxt    = 1'b1;
          w_commit    = r_shadow_valid;
        end
      end
      S_FETCH: begin
        if (w_edge) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
          w_en_nxt    = 1'b1;
          w_restart   = 1'b1;
        end else if (r_addr == LAST_ADDR) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_en_nxt    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_edge) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
          w_en_nxt    = 1'b1;
          w_restart   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow contents need no reset: shadow_valid gates every use of them
  always_ff @(posedge clk) begin
    if (r_cap_vld) begin
      if (r_cap_idx == '0) begin
        r_shadow_vbit  <= bram.filter_coeff_data[31];
        r_shadow_shift <= bram.filter_coeff_data[4:0];
      end
      for (int k = 0; k < NUM_COEFF; k++) begin
        if (r_cap_idx == ADDR_W'(k + 1)) begin
          r_shadow[k] <= bram.filter_coeff_data[COEFF_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_vld      <= 1'b0;
      r_cap_idx      <= '0;
      r_shadow_valid <= 1'b0;
      r_update       <= 1'b0;
      r_abort        <= 1'b0;
      r_shift        <= 5'(RST_SHIFT);
      for (int k = 0; k < NUM_COEFF; k++) begin
        r_coeff[k*COEFF_W +: COEFF_W] <= (k == CENTRE) ? ID_TAP : '0;
      end
    end else begin
      r_cap_vld <= r_en;
      r_cap_idx <= r_addr;
      r_update  <= w_commit;
      if (w_commit) begin
        for (int k = 0; k < NUM_COEFF; k++) begin
          r_coeff[k*COEFF_W +: COEFF_W] <= r_shadow[k];
        end
        r_shift <= r_shadow_shift;
      end
      if (w_restart) begin
        r_abort <= 1'b1;
      end
      if (w_edge) begin
        r_shadow_valid <= 1'b0;
      end else if (w_done) begin
        r_shadow_valid <= r_shadow_vbit;
      end
    end
  end

  assign bram.filter_coeff_addr = r_addr;
  assign bram.filter_coeff_en   = r_en;
  assign coeff_o  = r_coeff;
  assign shift_o  = r_shift;
  assign update_o = r_update;
  assign busy_o   = (r_state != S_IDLE);
  assign abort_o  = r_abort;
  assign w_unused = ^bram.filter_coeff_data;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: edge-level reference model of fetch/commit
// timing, per-cycle output compare, plus directed literal checks.
module tb_fir_coeff_loader;
  localparam int NC = 25;
  localparam int CW = 16;
  localparam int AW = 6;
  localparam int RS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            vs_i;
  logic [NC*CW-1:0] coeff_o;
  logic [4:0]      shift_o;
  logic            update_o;
  logic            busy_o;
  logic            abort_o;

  fir_coeff_loader_if #(.ADDR_W(AW)) bif ();

  fir_coeff_loader #(
    .NUM_COEFF(NC), .COEFF_W(CW), .ADDR_W(AW), .RST_SHIFT(RS)
  ) dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .bram(bif),
    .coeff_o(coeff_o), .shift_o(shift_o), .update_o(update_o),
    .busy_o(busy_o), .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (bif.filter_coeff_en) bif.filter_coeff_data <= mem[bif.filter_coeff_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 0;

  // Reference model: state only changes at reset and at vsync edges
  logic [CW-1:0] m_tap [NC];
  logic [4:0]    m_shift;
  bit            m_abort;
  int            m_upd_cyc;
  bit            m_live;
  int            m_fe;
  logic [31:0]   m_snap [NC+1];
  bit            m_vsq;

  task automatic chk(input string nm, input logic [NC*CW-1:0] act, input logic [NC*CW-1:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  function automatic void model_reset();
    m_live = 0;
    m_abort = 0;
    m_upd_cyc = -1;
    m_shift = 5'(RS);
    for (int k = 0; k < NC; k++) m_tap[k] = (k == NC/2) ? CW'(1 << RS) : '0;
  endfunction

  function automatic void model_edge(input int e);
    // Previous fetch finishes its last capture at fe+NC+2
    if (m_live && e <= m_fe + NC + 2) begin
      m_abort = 1;
    end else if (m_live && m_snap[0][31]) begin
      for (int k = 0; k < NC; k++) m_tap[k] = m_snap[k+1][CW-1:0];
      m_shift = m_snap[0][4:0];
      m_upd_cyc = e + 1;
    end
    m_live = 1;
    m_fe = e;
    for (int a = 0; a <= NC; a++) m_snap[a] = mem[a];
  endfunction

  task automatic step(input logic v, input logic r);
    bit e;
    vs_i = v;
    rst = r;
    e = v && !m_vsq && !r;
    @(posedge clk);
    #1;
    cyc++;
    m_vsq = r ? 1'b1 : v;
    if (r) begin
      model_reset();
      chk_on = 1;
    end else if (e) begin
      model_edge(cyc - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic vs_edge(input int hi);
    repeat (hi) step(1'b1, 1'b0);
  endtask

  function automatic bit mem_ok();
    return !(m_live && cyc <= m_fe + NC + 2);
  endfunction

  function automatic void fill(input logic [31:0] w0, input int base, input bit rnd);
    mem[0] = w0;
    for (int k = 0; k < NC; k++)
      mem[k+1] = {16'($urandom), rnd ? 16'($urandom) : 16'(base + k)};
  endfunction

  logic [NC*CW-1:0] ev;
  bit f_en;
  bit f_busy;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NC; k++) ev[k*CW +: CW] = m_tap[k];
      f_en   = m_live && cyc >= m_fe + 1 && cyc <= m_fe + NC + 1;
      f_busy = m_live && cyc >= m_fe + 1 && cyc <= m_fe + NC + 2;
      chk("coeff_o", coeff_o, ev);
      chk("shift_o", shift_o, m_shift);
      chk("update_o", update_o, cyc == m_upd_cyc);
      chk("busy_o", busy_o, f_busy);
      chk("abort_o", abort_o, m_abort);
      chk("en", bif.filter_coeff_en, f_en);
      chk("addr_range", bif.filter_coeff_addr <= AW'(NC), 1'b1);
      if (f_en) chk("addr", bif.filter_coeff_addr, AW'(cyc - m_fe - 1));
    end
  end

  initial begin
    int tgt;
    int hi;
    rst = 1'b1;
    vs_i = 1'b1;
    m_vsq = 1;
    model_reset();
    for (int a = 0; a < 64; a++) mem[a] = '0;

    // Reset with vsync held high: no edge on release
    repeat (3) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    chk("lit_reset_tap12", coeff_o[12*CW +: CW], 16'd256);
    chk("lit_reset_tap0", coeff_o[0 +: CW], 16'd0);
    chk("lit_reset_shift", shift_o, 5'd8);
    chk("lit_reset_en", bif.filter_coeff_en, 1'b0);
    chk("lit_reset_busy", busy_o, 1'b0);
    idle(3);

    // Valid set, taps k+1, shift 4
    fill(32'h8000_0004, 1, 0);
    vs_edge(1);
    chk("lit_e1_update", update_o, 1'b0);
    idle(26);
    chk("lit_busy_e27", busy_o, 1'b1);
    idle(1);
    chk("lit_busy_e28", busy_o, 1'b0);
    idle(12);
    vs_edge(1);
    chk("lit_e2_update", update_o, 1'b1);
    chk("lit_e2_tap0", coeff_o[0 +: CW], 16'd1);
    chk("lit_e2_tap24", coeff_o[24*CW +: CW], 16'd25);
    chk("lit_e2_shift", shift_o, 5'd4);
    idle(40);

    // Invalid set is dropped
    step(1'b0, 1'b1);
    fill(32'h0000_0004, 0, 1);
    idle(2);
    vs_edge(1);
    idle(40);
    vs_edge(1);
    idle(40);
    chk("lit_inv_tap12", coeff_o[12*CW +: CW], 16'd256);
    chk("lit_inv_shift", shift_o, 5'd8);

    // Edge 10 clocks after the previous one aborts the fetch
    fill(32'h8000_0003, 16'h0100, 0);
    idle(2);
    vs_edge(1);
    idle(9);
    vs_edge(1);
    chk("lit_abort", abort_o, 1'b1);
    chk("lit_abort_update", update_o, 1'b0);
    idle(40);
    vs_edge(1);
    chk("lit_after_abort_update", update_o, 1'b1);
    chk("lit_after_abort_tap0", coeff_o[0 +: CW], 16'h0100);
    chk("lit_after_abort_shift", shift_o, 5'd3);

    // BRAM rewritten mid-frame: old shadow commits, new data loads after
    idle(35);
    fill(32'h8000_0005, 16'h0200, 0);
    idle(5);
    chk("lit_midframe_tap0", coeff_o[0 +: CW], 16'h0100);
    vs_edge(1);
    chk("lit_old_shadow_tap0", coeff_o[0 +: CW], 16'h0100);
    idle(40);
    vs_edge(1);
    chk("lit_new_tap0", coeff_o[0 +: CW], 16'h0200);
    chk("lit_new_shift", shift_o, 5'd5);

    // Reset mid-fetch
    idle(3);
    vs_edge(1);
    idle(5);
    step(1'b0, 1'b1);
    chk("lit_rst_busy", busy_o, 1'b0);
    chk("lit_rst_en", bif.filter_coeff_en, 1'b0);
    chk("lit_rst_tap12", coeff_o[12*CW +: CW], 16'd256);
    chk("lit_rst_abort", abort_o, 1'b0);
    idle(3);
    vs_edge(1);
    chk("lit_rst_nocommit", update_o, 1'b0);
    chk("lit_rst_refetch", busy_o, 1'b1);
    idle(30);

    // Randomized edge spacing around the fetch-completion boundary
    for (int it = 0; it < 50; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(1, 26));
        repeat ($urandom_range(1, 2)) step(1'b0, 1'b1);
      end
      if (mem_ok() && $urandom_range(0, 3) != 0)
        fill({($urandom_range(0, 3) != 0), 26'($urandom), 5'($urandom)}, 0, 1);
      case ($urandom_range(0, 5))
        0, 1:    tgt = $urandom_range(3, 26);
        2:       tgt = 27;
        3:       tgt = 28;
        default: tgt = $urandom_range(29, 45);
      endcase
      hi = $urandom_range(1, 2);
      idle(tgt - hi);
      vs_edge(hi);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
